// File: rtl/key_matrix_scanner.sv
// Scans a 6x8 active-low key matrix one row at a time and publishes a
// debounced 48-bit key map once the same full frame has been seen DEB_FRAMES times.
module key_matrix_scanner #(
    parameter int SCAN_DIV   = 50000,
    parameter int DEB_FRAMES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  col_in,
    output logic [5:0]  row_out,
    output logic [47:0] keys,
    output logic        changed,
    output logic        any_key
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int STB_W = $clog2(DEB_FRAMES + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [STB_W-1:0] STB_MAX  = STB_W'(DEB_FRAMES);

    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       row;
    logic [47:0]      frame;
    logic [47:0]      last_frame;
    logic [47:0]      full_frame;
    logic [STB_W-1:0] stable_cnt;
    logic [STB_W-1:0] stable_next;
    logic             sample_edge;
    logic             frame_done;

    // The row-5 columns are spliced in live so the frame can be judged on its own sample edge.
    always_comb begin
        sample_edge = (div_cnt == DIV_LAST);
        frame_done  = sample_edge && (row == 3'd5);
        full_frame  = {~col_in, frame[39:0]};
        if (full_frame != last_frame) begin
            stable_next = STB_W'(1);
        end else if (stable_cnt == STB_MAX) begin
            stable_next = stable_cnt;
        end else begin
            stable_next = stable_cnt + STB_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt    <= '0;
            row        <= 3'd0;
            row_out    <= 6'b111110;
            frame      <= '0;
            last_frame <= '0;
            stable_cnt <= '0;
            keys       <= '0;
            changed    <= 1'b0;
            any_key    <= 1'b0;
        end else begin
            changed <= 1'b0;
            if (sample_edge) begin
                div_cnt                   <= '0;
                frame[{row, 3'b000} +: 8] <= ~col_in;
                row_out                   <= {row_out[4:0], row_out[5]};
                row                       <= (row == 3'd5) ? 3'd0 : row + 3'd1;
                if (frame_done) begin
                    stable_cnt <= stable_next;
                    if (full_frame != last_frame) begin
                        last_frame <= full_frame;
                    end
                    if ((stable_next == STB_MAX) && (full_frame != keys)) begin
                        keys    <= full_frame;
                        any_key <= |full_frame;
                        changed <= 1'b1;
                    end
                end
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: doc/key_matrix_scanner.md
KEY_MATRIX_SCANNER -- requirements
Module: key_matrix_scanner

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 50000, meaning clock cycles each row is driven (1 ms at 50 MHz); legal values are 2 or more.
REQ-002 The block SHALL have parameter DEB_FRAMES, default 4, meaning consecutive identical full-matrix frames required before keys updates; legal values are 1 or more.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port col_in, input, 8 bits: matrix columns, active-low (pulled up; a pressed key on the driven row reads 0).
REQ-006 The block SHALL have port row_out, output, 6 bits: matrix rows, active-low one-hot drive.
REQ-007 The block SHALL have port keys, output, 48 bits: debounced key state, 1 = pressed, index = row*8 + col; it feeds the player's keys input directly.
REQ-008 The block SHALL have port changed, output, 1 bit: one-cycle pulse when keys changes.
REQ-009 The block SHALL have port any_key, output, 1 bit: OR of keys.

Function
REQ-010 row_out SHALL have exactly one bit low in every cycle, including during reset.
REQ-011 Dwell counter div_cnt SHALL count 0..SCAN_DIV-1 and then wrap to 0.
REQ-012 On the edge where div_cnt = SCAN_DIV-1, the block SHALL store ~col_in into frame bits [row*8 +: 8] and advance the row index (5 wraps to 0), so row_out moves on that same edge.
REQ-013 A frame SHALL complete on the row-5 sample edge; the evaluated frame is the row 0..4 buffer plus the row-5 data sampled on that edge.
REQ-014 At frame completion, if the frame differs from last_frame: last_frame <= frame and stable_cnt <= 1.
REQ-015 At frame completion, if the frame equals last_frame: stable_cnt <= stable_cnt+1, saturating at DEB_FRAMES.
REQ-016 On the frame-completion edge where the updated stable_cnt equals DEB_FRAMES and the frame differs from keys, the block SHALL set keys <= frame; changed SHALL be 1 for exactly the following cycle.
REQ-017 keys SHALL change only on frame-completion edges.
REQ-018 A saturated, unchanged matrix SHALL produce no further changed pulses.
REQ-019 With DEB_FRAMES = 1, keys SHALL follow every completed frame.
REQ-020 Any number of simultaneous keys SHALL update together on one edge with a single changed pulse.
REQ-021 Press latency SHALL be DEB_FRAMES full frames after the first frame containing the press, i.e. at most (DEB_FRAMES+1)*6*SCAN_DIV cycles from the press.
REQ-022 Release SHALL be debounced identically to press.
REQ-023 any_key SHALL be registered alongside keys and SHALL equal |keys in every cycle.
REQ-024 Counter widths SHALL be sized from the parameters; no counter may overflow at its maximum parameter value.

Reset
REQ-025 While reset = 1, on each edge: row_out = 6'b111110, div_cnt = 0, row = 0, frame buffer = 0, last_frame = 0, stable_cnt = 0, keys = 0, changed = 0, any_key = 0.
REQ-026 Reset asserted mid-frame or mid-debounce SHALL discard partial data; scanning restarts at row 0 on the first edge after reset deasserts.

Verification (SCAN_DIV = 4, DEB_FRAMES = 3, frame = 24 cycles)
REQ-027 Reset check: apply reset, then release it -> row_out = 6'b111110, keys = 0, changed = 0; after 4 cycles row_out = 6'b111101; after 24 cycles row_out = 6'b111110 again.
REQ-028 Press: col_in[3] = 0 whenever row_out[2] = 0, held -> keys = 48'h0000_0008_0000 (bit 19) after the 3rd matching frame completes; exactly one changed pulse; any_key = 1.
REQ-029 Bounce: key 19 present for only 2 frames, then absent -> keys remains 0 and changed never pulses.
REQ-030 Simultaneous press: keys 0 and 47 pressed -> bits 0 and 47 set on the same edge with a single changed pulse.
REQ-031 Release: key 19 released after being registered -> keys[19] clears 3 frames later with one changed pulse; any_key = 0.
REQ-032 Mid-operation reset: reset for 1 cycle at row 3 while keys = bit 19 -> next cycle keys = 0, row_out = 6'b111110; re-registration takes the full 3 frames again.
